// File: rtl/mdu_hilo_if.sv
// Handshake/bus bundle between the control unit and the multiply/divide unit.
// The abort signal exists only when MDU_ABORT_EN is defined.
interface mdu_hilo_if;
   logic        start;
   logic [1:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        we_hi;
   logic        we_lo;
   logic [31:0] wd;
`ifdef MDU_ABORT_EN
   logic        abort;
`endif
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   modport master (
      output start, op, a, b, we_hi, we_lo, wd,
`ifdef MDU_ABORT_EN
      output abort,
`endif
      input  busy, done, hi, lo
   );

   modport slave (
      input  start, op, a, b, we_hi, we_lo, wd,
`ifdef MDU_ABORT_EN
      input  abort,
`endif
      output busy, done, hi, lo
   );
endinterface

// File: rtl/mdu_hilo.sv
// Iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO registers, fixed 34-cycle latency.
// Optional feature: define MDU_ABORT_EN to add an abort input that cancels an in-flight operation.
module mdu_hilo #(
   parameter logic [31:0] RESET_HILO = 32'h0
) (
   input logic         clk,
   input logic         rst_n,
   mdu_hilo_if.slave   bus
);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX} state_t;

   state_t      r_state;
   logic        r_busy;
   logic        r_done;
   logic [31:0] r_hi;
   logic [31:0] r_lo;
   logic [5:0]  r_cnt;
   logic [63:0] r_acc;
   logic [31:0] r_opX;
   logic        r_isDiv;
   logic        r_negQ;
   logic        r_negR;
   logic        r_divZero;

   logic        w_isSigned;
   logic        w_isDiv;
   logic [31:0] w_absA;
   logic [31:0] w_absB;
   logic        w_abort;
   logic [32:0] w_mulSum;
   logic [32:0] w_divRem;
   logic        w_divGe;
   logic [31:0] w_divSub;
   logic [63:0] w_accNext;
   logic [63:0] w_prod;
   logic [31:0] w_quo;
   logic [31:0] w_rem;

`ifdef MDU_ABORT_EN
   assign w_abort = bus.abort;
`else
   assign w_abort = 1'b0;
`endif

   assign w_isSigned = bus.op[0];
   assign w_isDiv    = bus.op[1];
   assign w_absA     = (w_isSigned && bus.a[31]) ? (~bus.a + 32'd1) : bus.a;
   assign w_absB     = (w_isSigned && bus.b[31]) ? (~bus.b + 32'd1) : bus.b;

   // Multiply keeps the multiplier in the low half and shifts it out LSB first;
   // divide shifts the dividend into the remainder half and quotient bits into the low half.
   assign w_mulSum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_opX} : 33'd0);
   assign w_divRem  = r_acc[63:31];
   assign w_divGe   = (w_divRem >= {1'b0, r_opX});
   assign w_divSub  = w_divRem[31:0] - r_opX;
   assign w_accNext = r_isDiv ? (w_divGe ? {w_divSub, r_acc[30:0], 1'b1}
                                         : {r_acc[62:0], 1'b0})
                              : {w_mulSum, r_acc[31:1]};

   // A zero divisor leaves the magnitude of a in the remainder, so only LO needs overriding.
   assign w_prod = r_negQ ? (~r_acc + 64'd1) : r_acc;
   assign w_quo  = r_divZero ? 32'hFFFF_FFFF
                             : (r_negQ ? (~r_acc[31:0] + 32'd1) : r_acc[31:0]);
   assign w_rem  = r_negR ? (~r_acc[63:32] + 32'd1) : r_acc[63:32];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= S_IDLE;
         r_busy    <= 1'b0;
         r_done    <= 1'b0;
         r_hi      <= RESET_HILO;
         r_lo      <= RESET_HILO;
         r_cnt     <= 6'd0;
         r_acc     <= 64'd0;
         r_opX     <= 32'd0;
         r_isDiv   <= 1'b0;
         r_negQ    <= 1'b0;
         r_negR    <= 1'b0;
         r_divZero <= 1'b0;
      end else begin
         r_done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (bus.we_hi) r_hi <= bus.wd;
               if (bus.we_lo) r_lo <= bus.wd;
               if (bus.start) begin
                  r_state   <= S_RUN;
                  r_busy    <= 1'b1;
                  r_cnt     <= 6'd0;
                  r_isDiv   <= w_isDiv;
                  r_opX     <= w_isDiv ? w_absB : w_absA;
                  r_acc     <= {32'd0, (w_isDiv ? w_absA : w_absB)};
                  r_negQ    <= w_isSigned & (bus.a[31] ^ bus.b[31]);
                  r_negR    <= w_isSigned & w_isDiv & bus.a[31];
                  r_divZero <= w_isDiv & (bus.b == 32'd0);
               end
            end
            S_RUN: begin
               if (w_abort) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  r_acc <= w_accNext;
                  r_cnt <= r_cnt + 6'd1;
                  if (r_cnt == 6'd31) r_state <= S_FIX;
               end
            end
            S_FIX: begin
               if (w_abort) begin
                  r_state <= S_IDLE;
                  r_busy  <= 1'b0;
               end else begin
                  if (r_isDiv) begin
                     r_hi <= w_rem;
                     r_lo <= w_quo;
                  end else begin
                     r_hi <= w_prod[63:32];
                     r_lo <= w_prod[31:0];
                  end
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign bus.busy = r_busy;
   assign bus.done = r_done;
   assign bus.hi   = r_hi;
   assign bus.lo   = r_lo;

endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit sitting directly downstream of the register file read ports in the MIPS datapath. It consumes the two source operands (rs/rt values) for MULT/MULTU/DIV/DIVU, computes the 64-bit product or the quotient/remainder over multiple cycles, and holds the results in architectural HI/LO registers. It also services MTHI/MTLO writes and exposes `busy` so the control unit can stall MFHI/MFLO and back-to-back mul/div instructions.

## Interface
Parameters:
- `RESET_HILO`, default `32'h0`: value loaded into HI and LO on reset.

Ports:
- `clk` in 1: single clock, all state updates on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: launch operation; honoured only while `busy`=0.
- `op` in 2: `00` MULTU, `01` MULT, `10` DIVU, `11` DIV; sampled with `start`.
- `a` in 32: rs operand (multiplicand / dividend), sampled with `start`.
- `b` in 32: rt operand (multiplier / divisor), sampled with `start`.
- `we_hi` in 1: MTHI write enable.
- `we_lo` in 1: MTLO write enable.
- `wd` in 32: MTHI/MTLO write data.
- `abort` in 1: present only with `MDU_ABORT_EN`; cancel in-flight operation.
- `busy` out 1: operation in flight.
- `done` out 1: one-cycle completion pulse.
- `hi` out 32: HI register.
- `lo` out 32: LO register.

## Operation
- States: IDLE, RUN, FIX.
- IDLE, `start`=1: latch `op`; for signed ops latch |a|, |b| and result sign flags; clear 6-bit iteration counter and 64-bit working accumulator; go to RUN.
- RUN: one iteration per cycle, exactly 32 iterations, then FIX.
  - Multiply: shift-add, one multiplier bit per cycle, LSB first.
  - Divide: restoring, one quotient bit per cycle, MSB first.
- FIX: apply sign correction; write HI/LO; pulse `done`; go to IDLE.
- Multiply result: HI = product[63:32], LO = product[31:0]; signed product negated as 64-bit value when sign(a) xor sign(b).
- Divide result: LO = quotient, HI = remainder. Signed: quotient negative iff sign(a) xor sign(b); remainder takes the sign of `a`.
- Divide by zero: LO = `32'hFFFF_FFFF`, HI = `a` (original, un-negated), for both DIV and DIVU.
- DIV `32'h8000_0000` / `32'hFFFF_FFFF`: LO = `32'h8000_0000`, HI = 0.
- HI/LO hold their previous values throughout RUN; they change only in FIX or on an MTHI/MTLO write.
- `start` while `busy`=1: ignored.
- `we_hi`/`we_lo` while `busy`=1: dropped.
- `we_hi`/`we_lo` in IDLE: write `wd` on the next edge.
  - If `start` arrives in the same cycle, the write still lands and the operation result later overwrites it.
  - `we_hi` and `we_lo` together write `wd` to both.

## Timing
- Reset (async assert): state IDLE, `busy`=0, `done`=0, `hi`=`lo`=`RESET_HILO`, counter=0. Reset mid-operation abandons it with no `done`.
- `start` sampled at edge 0: `busy`=1 from after edge 0; RUN occupies edges 1–32; FIX at edge 33.
- After edge 33: `hi`/`lo` hold the result, `done`=1 for exactly one cycle, `busy`=0.
- Total latency: start to result is 34 cycles, fixed and data-independent.
- A new `start` is accepted in the same cycle `done` is high.
- `busy` and `done` are registered outputs, never both 1.

## Configuration
- `MDU_ABORT_EN` defined: `abort` port exists.
  - `abort`=1 in RUN or FIX returns to IDLE on the next edge with `busy`=0 and no `done`; HI/LO unchanged.
  - `abort` in IDLE has no effect.
  - `abort` has priority over FIX completion in the same cycle.
- `MDU_ABORT_EN` undefined: no `abort` port; operations always run to completion.

## Test plan
- Reset, then MULTU a=`32'hFFFF_FFFF` b=`32'hFFFF_FFFF` -> `done` 34 cycles after `start`; HI=`32'hFFFF_FFFE`, LO=`32'h0000_0001`.
- MULT a=-3 (`32'hFFFF_FFFD`) b=7 -> HI=`32'hFFFF_FFFF`, LO=`32'hFFFF_FFEB`; HI/LO keep prior values until `done`.
- DIV a=-7 b=2 -> LO=`32'hFFFF_FFFD`, HI=`32'hFFFF_FFFF`. DIVU a=100 b=0 -> LO=`32'hFFFF_FFFF`, HI=100.
- DIV `32'h8000_0000` / `32'hFFFF_FFFF` -> LO=`32'h8000_0000`, HI=0. MTHI `32'h1234` while `busy` -> dropped, HI unchanged.
- Second `start` pulsed mid-RUN -> ignored. `start` on the `done` cycle -> accepted, next `done` 34 cycles later.
- Assert `rst_n`=0 at RUN cycle 10 -> `busy`=0, HI=LO=`RESET_HILO`, no `done`. With `MDU_ABORT_EN`: `abort` at cycle 10 -> IDLE, HI/LO unchanged, no `done`.
